// File: rtl/debounce_pkg.sv
// Board timing constants shared by the switch debounce blocks.
// Lets users size debounce and hold windows in physical units.
package debounce_pkg;

   localparam int CLK_HZ    = 25_000_000;
   localparam int MS_CYCLES = CLK_HZ / 1000;
   localparam int S_CYCLES  = CLK_HZ;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: synchroniser, restart-on-glitch debounce,
// edge pulses and a one-shot long-press pulse.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_COUNT = MS_CYCLES,
   parameter int SYNC_STAGES    = 2,
   parameter int HOLD_COUNT     = S_CYCLES
) (
   input  logic clock,
   input  logic reset_n,
   input  logic sw_input,
   output logic debounced,
   output logic rise,
   output logic fall,
   output logic held
);

   localparam int CNT_W  = $clog2(DEBOUNCE_COUNT + 1);
   localparam int HOLD_W =
      (HOLD_COUNT > 0) ? $clog2(HOLD_COUNT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DEBOUNCE_COUNT);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic [CNT_W-1:0]       cnt;
   logic                   accept;

   assign sync   = sync_q[SYNC_STAGES-1];
   assign accept = (sync != debounced) && (cnt == '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sw_input};
      end
   end

   // Any cycle where sync agrees with the output restarts the window.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= CNT_INIT;
         debounced <= 1'b0;
         rise      <= 1'b0;
         fall      <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync == debounced) begin
            cnt <= CNT_INIT;
         end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end else begin
            cnt       <= CNT_INIT;
            debounced <= sync;
            rise      <= sync;
            fall      <= ~sync;
         end
      end
   end

   generate
      if (HOLD_COUNT > 0) begin : g_hold
         localparam logic [HOLD_W-1:0] HOLD_LAST =
            HOLD_W'(HOLD_COUNT - 1);

         logic [HOLD_W-1:0] hcnt;
         logic              done;
         logic              held_q;

         // A release accepted this edge suppresses a coincident pulse.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               hcnt   <= '0;
               done   <= 1'b0;
               held_q <= 1'b0;
            end else if (!debounced || accept) begin
               hcnt   <= '0;
               done   <= 1'b0;
               held_q <= 1'b0;
            end else if (!done) begin
               hcnt   <= hcnt + 1'b1;
               held_q <= (hcnt == HOLD_LAST);
               done   <= (hcnt == HOLD_LAST);
            end else begin
               held_q <= 1'b0;
            end
         end

         assign held = held_q;
      end else begin : g_no_hold
         assign held = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent switch debouncers, one channel per input pin.
// All channels share clock, reset and timing parameters.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int CHANNELS       = 4,
   parameter int DEBOUNCE_COUNT = MS_CYCLES,
   parameter int SYNC_STAGES    = 2,
   parameter int HOLD_COUNT     = S_CYCLES
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] sw_input,
   output logic [CHANNELS-1:0] debounced,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] held
);

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
         debounce_channel #(
            .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
            .SYNC_STAGES    (SYNC_STAGES),
            .HOLD_COUNT     (HOLD_COUNT)
         ) u_ch (
            .clock     (clock),
            .reset_n   (reset_n),
            .sw_input  (sw_input[i]),
            .debounced (debounced[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .held      (held[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with small debounce/hold windows.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_debounce_bank;

   logic       clock;
   logic       reset_n;
   logic [3:0] sw_input;
   logic [3:0] debounced;
   logic [3:0] rise;
   logic [3:0] fall;
   logic [3:0] held;

   int errors;
   int checks;

   debounce_bank #(
      .CHANNELS       (4),
      .DEBOUNCE_COUNT (3),
      .SYNC_STAGES    (2),
      .HOLD_COUNT     (10)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .sw_input  (sw_input),
      .debounced (debounced),
      .rise      (rise),
      .fall      (fall),
      .held      (held)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      reset_n  = 1'b0;
      sw_input = 4'b0000;
      tick(3);
      chk("reset_state", {debounced, rise, fall, held}, 0);
      reset_n = 1'b1;

      // 1: idle inputs never produce activity
      for (int k = 0; k < 20; k++) begin
         tick(1);
         chk("idle", {debounced, rise, fall, held}, 0);
      end

      // 2: ch0 press, 6 cycle latency, single rise pulse
      sw_input[0] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         chk("ch0_wait", {debounced, rise}, 0);
      end
      tick(1);
      chk("ch0_db", 32'(debounced), 32'h1);
      chk("ch0_rise", 32'(rise), 32'h1);
      tick(1);
      chk("ch0_rise_once", 32'(rise), 0);
      chk("ch0_db_hold", 32'(debounced), 32'h1);

      // 3: ch1 glitch restarts the window
      sw_input[1] = 1'b1;
      tick(3);
      sw_input[1] = 1'b0;
      tick(1);
      sw_input[1] = 1'b1;
      tick(3);
      chk("ch1_glitch_db", 32'(debounced[1]), 0);
      chk("ch1_glitch_rise", 32'(rise[1]), 0);
      tick(2);
      chk("ch1_pre_rise", 32'(rise[1]), 0);
      tick(1);
      chk("ch1_rise", 32'(rise[1]), 1);
      chk("ch1_db", 32'(debounced[1]), 1);

      // 4: ch2 long press, one held pulse, then release
      sw_input[2] = 1'b1;
      tick(6);
      chk("ch2_rise", 32'(rise[2]), 1);
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         chk("ch2_held", 32'(held[2]), (k == 10) ? 1 : 0);
      end
      sw_input[2] = 1'b0;
      tick(5);
      chk("ch2_pre_fall", {31'(0), fall[2]}, 0);
      chk("ch2_db_still", 32'(debounced[2]), 1);
      tick(1);
      chk("ch2_fall", 32'(fall[2]), 1);
      chk("ch2_db_low", 32'(debounced[2]), 0);
      chk("ch2_no_rise", 32'(rise[2]), 0);

      // 5: ch3 short press, re-press, then release on hold terminal
      sw_input[3] = 1'b1;
      tick(6);
      chk("ch3_rise", 32'(rise[3]), 1);
      tick(2);
      sw_input[3] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         chk("ch3_short_held", 32'(held[3]), 0);
         chk("ch3_short_fall", 32'(fall[3]), (k == 6) ? 1 : 0);
      end
      sw_input[3] = 1'b1;
      tick(6);
      chk("ch3_rise2", 32'(rise[3]), 1);
      for (int k = 1; k <= 11; k++) begin
         tick(1);
         chk("ch3_held2", 32'(held[3]), (k == 10) ? 1 : 0);
      end
      sw_input[3] = 1'b0;
      tick(6);
      chk("ch3_fall2", 32'(fall[3]), 1);
      sw_input[3] = 1'b1;
      tick(6);
      chk("ch3_rise3", 32'(rise[3]), 1);
      tick(4);
      sw_input[3] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         chk("ch3_coinc_held", 32'(held[3]), 0);
         chk("ch3_coinc_fall", 32'(fall[3]), (k == 6) ? 1 : 0);
      end

      // 6: asynchronous reset mid-count (ch0) and mid-hold (ch2)
      sw_input[0] = 1'b0;
      sw_input[2] = 1'b1;
      tick(6);
      chk("ch0_fall", 32'(fall[0]), 1);
      chk("ch2_rise_b", 32'(rise[2]), 1);
      sw_input[0] = 1'b1;
      tick(3);
      #2 reset_n = 1'b0;
      #1 chk("async_reset", {debounced, rise, fall, held}, 0);
      tick(2);
      chk("reset_hold", {debounced, rise, fall, held}, 0);
      reset_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         chk("post_reset_quiet", {debounced, rise, fall, held}, 0);
      end
      tick(1);
      chk("post_reset_rise", 32'(rise), 32'h7);
      chk("post_reset_db", 32'(debounced), 32'h7);
      for (int k = 1; k <= 11; k++) begin
         tick(1);
         chk("post_reset_held", 32'(held), (k == 10) ? 32'h7 : 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
Multi-channel, parametrised successor to the single-switch debouncer. It takes N raw, asynchronous switch/button inputs and synchronises each into the clock domain. Each channel is debounced with a counter that restarts on any glitch. Per channel it produces the debounced level, one-cycle press/release pulses and a one-shot long-press pulse. It sits between board pins and the user-logic FSMs (menus, counters, LED demos) on the Go board.

Parameters:
CHANNELS, 4, number of independent switch channels (1..32)
DEBOUNCE_COUNT, 25000, stable cycles minus one required before the level is accepted (1 ms at 25 MHz); must be >= 1
SYNC_STAGES, 2, synchroniser flops per channel (2..4)
HOLD_COUNT, 25000000, cycles the debounced level must stay 1 before `held` pulses (1 s at 25 MHz); 0 disables long-press detection
CNT_W, derived $clog2(DEBOUNCE_COUNT+1), debounce counter width; not overridable
HOLD_W, derived $clog2(HOLD_COUNT+1) (min 1), hold counter width; not overridable

Ports:
clock  input  1  system clock, all logic on the rising edge
reset_n  input  1  asynchronous, active-low reset; one clock, asynchronous active-low reset, no other reset source
sw_input  input  CHANNELS  raw switch levels, asynchronous, 1 = pressed
debounced  output  CHANNELS  debounced level per channel
rise  output  CHANNELS  one-cycle pulse, same cycle debounced goes 0->1
fall  output  CHANNELS  one-cycle pulse, same cycle debounced goes 1->0
held  output  CHANNELS  one-cycle pulse when a press has lasted HOLD_COUNT cycles

Behaviour:
- Reset (reset_n low, asserted asynchronously, released synchronously by the board-level reset synchroniser):
  - synchroniser flops = 0, debounced = 0, rise = fall = held = 0
  - debounce counter = DEBOUNCE_COUNT, hold counter = 0, held_done = 0
- Synchroniser: sw_input[i] passes through SYNC_STAGES flops; the last stage is `sync[i]`. No logic between stages.
- Debounce, per channel, evaluated every cycle:
  - sync == debounced: counter reloads to DEBOUNCE_COUNT. Any glitch restarts the count; this is a change from the previous single-channel block, which paused on a glitch.
  - sync != debounced and counter != 0: counter decrements by 1.
  - sync != debounced and counter == 0: debounced <= sync, counter reloads, and rise (new 1) or fall (new 0) is asserted for exactly that cycle.
- Latency:
  - A mismatch must persist DEBOUNCE_COUNT+1 consecutive cycles at `sync` to be accepted.
  - Raw edge to debounced edge = SYNC_STAGES + DEBOUNCE_COUNT + 1 cycles.
- rise/fall:
  - registered; high for exactly one cycle, coincident with the first cycle of the new debounced value
  - never both high on one channel in the same cycle
- Long press (HOLD_COUNT > 0):
  - While debounced == 1 and held_done == 0, the hold counter increments by 1 per cycle.
  - When it equals HOLD_COUNT−1 on an increment, held pulses for one cycle next edge and held_done <= 1; the counter then stops. This gives exactly HOLD_COUNT cycles after rise.
  - At most one held pulse per press.
  - When debounced == 0, the hold counter and held_done clear.
  - If fall coincides with the hold terminal cycle, fall wins and no held pulse is emitted.
- HOLD_COUNT == 0: held is tied to 0; hold logic is not generated.
- Channels are fully independent; simultaneous events on different channels all report in the same cycle.
- No arithmetic wrap: the debounce counter never decrements below 0 and the hold counter never exceeds HOLD_COUNT.
- Reset mid-operation: all in-flight counts are discarded and no pulse is emitted on reset release. A switch already pressed at release produces a rise after the normal latency.

Decomposition:
- Shared package debounce_pkg:
  - board clock frequency constant CLK_HZ = 25_000_000
  - helper constants MS_CYCLES = CLK_HZ/1000 and S_CYCLES = CLK_HZ, so users set DEBOUNCE_COUNT/HOLD_COUNT in physical units
- Sub-module debounce_channel: one synchroniser + debounce counter + hold counter + pulse logic, carrying the same parameters minus CHANNELS.
- debounce_bank is a generate loop over CHANNELS instances.

Test Plan:
Bench parameters: CHANNELS=4, DEBOUNCE_COUNT=3, SYNC_STAGES=2, HOLD_COUNT=10.
1. Reset, then hold sw_input=4'b0000 for 20 cycles -> debounced=0, no rise/fall/held pulses at any time.
2. sw_input[0] 0->1 and held -> debounced[0] rises exactly 6 cycles after the edge (2+3+1); rise[0] high that cycle only; other channels stay 0.
3. sw_input[1] = 1 for 3 cycles, 0 for 1 cycle, then 1 for 3 cycles -> no change on debounced[1], because the glitch restarted the counter. Holding a further 3 cycles -> rise[1].
4. Press ch2 and keep it pressed -> held[2] pulses once, 10 cycles after rise[2]; no further held while still pressed. Release -> fall[2] after 6 cycles.
5. Press ch3 for 8 debounced cycles, then release -> fall[3], no held[3]. Press again -> a fresh count gives held[3] 10 cycles after the new rise.
6. Assert reset_n low mid-count on ch0 and mid-hold on ch2 -> all outputs 0 immediately (asynchronous). After release with inputs still 1 -> rise on both 6 cycles later; no held until 10 further cycles.
